// File: rtl/fft_pkg.sv
// Shared constants and types for the 8-point radix-2 FFT twiddle sequencer.
package fft_pkg;

    localparam int N_PTS   = 8;
    localparam int N_STAGE = 3;
    localparam int N_BFLY  = 4;
    // Only W8^0..W8^3 occur in a radix-2 DIT 8-point frame
    localparam int K_W     = $clog2(N_PTS) - 1;

    localparam logic [31:0] FP_ONE       = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
    localparam logic [31:0] FP_RSQRT2    = 32'h3F35_04F3;
    localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/twiddle_rom.sv
// Combinational W8^k lookup; inverse mode conjugates and drops the -j bypass flag.
module twiddle_rom
    import fft_pkg::*;
(
    input  logic [K_W-1:0] i_k,
    input  logic           i_inverse,
    output logic [31:0]    o_re,
    output logic [31:0]    o_im,
    output logic           o_is_mj
);

    always_comb begin
        o_re    = FP_ONE;
        o_im    = FP_ZERO;
        o_is_mj = 1'b0;
        case (i_k)
            2'd1: begin
                o_re = FP_RSQRT2;
                o_im = FP_RSQRT2 | FP_SIGN_MASK;
            end
            2'd2: begin
                o_re    = FP_ZERO;
                o_im    = FP_ONE | FP_SIGN_MASK;
                o_is_mj = 1'b1;
            end
            2'd3: begin
                o_re = FP_RSQRT2 | FP_SIGN_MASK;
                o_im = FP_RSQRT2 | FP_SIGN_MASK;
            end
            default: ;
        endcase
        // k=0 is excluded so the conjugate of +0 never becomes -0
        if (i_inverse && (i_k != '0)) begin
            o_im    = o_im ^ FP_SIGN_MASK;
            o_is_mj = 1'b0;
        end
    end

endmodule

// File: rtl/twiddle_seq.sv
// Emits the 12 butterfly twiddles of an 8-point radix-2 FFT frame, one per accepted adv.
module twiddle_seq
    import fft_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         inverse,
    input  logic         adv,
    output logic [W-1:0] w_re,
    output logic [W-1:0] w_im,
    output logic         is_mj,
    output logic         tw_valid,
    output logic [1:0]   stage,
    output logic [1:0]   bfly,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] LAST_STG = 2'(N_STAGE - 1);
    localparam logic [1:0] LAST_BF  = 2'(N_BFLY - 1);

    state_t         r_state;
    state_t         w_next;
    logic           w_start_acc;
    logic           w_adv_acc;
    logic           r_inv;
    logic [1:0]     r_stg;
    logic [1:0]     r_bf;
    logic [K_W-1:0] w_k;
    logic [31:0]    w_rom_re;
    logic [31:0]    w_rom_im;
    logic           w_rom_mj;

    logic [W-1:0]   r_re;
    logic [W-1:0]   r_im;
    logic           r_mj;
    logic           r_tw_valid;
    logic [1:0]     r_stage_o;
    logic [1:0]     r_bfly_o;
    logic           r_busy;
    logic           r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_adv_acc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = S_RUN;
                end
            end
            S_RUN: begin
                if (adv) begin
                    w_adv_acc = 1'b1;
                    if ((r_stg == LAST_STG) && (r_bf == LAST_BF)) w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stage 0 is all W8^0; stage 1 alternates W8^0/W8^2; stage 2 walks W8^0..W8^3
    always_comb begin
        case (r_stg)
            2'd0:    w_k = '0;
            2'd1:    w_k = {r_bf[0], 1'b0};
            default: w_k = r_bf;
        endcase
    end

    twiddle_rom u_rom (
        .i_k       (w_k),
        .i_inverse (r_inv),
        .o_re      (w_rom_re),
        .o_im      (w_rom_im),
        .o_is_mj   (w_rom_mj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv      <= 1'b0;
            r_stg      <= '0;
            r_bf       <= '0;
            r_re       <= '0;
            r_im       <= '0;
            r_mj       <= 1'b0;
            r_tw_valid <= 1'b0;
            r_stage_o  <= '0;
            r_bfly_o   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tw_valid <= w_adv_acc;
            r_done     <= (r_state == S_DONE);
            if (r_state == S_DONE) r_busy <= 1'b0;
            if (w_start_acc) begin
                r_inv     <= inverse;
                r_stg     <= '0;
                r_bf      <= '0;
                r_stage_o <= '0;
                r_bfly_o  <= '0;
                r_busy    <= 1'b1;
            end else if (w_adv_acc) begin
                r_re      <= w_rom_re;
                r_im      <= w_rom_im;
                r_mj      <= w_rom_mj;
                r_stage_o <= r_stg;
                r_bfly_o  <= r_bf;
                if (r_bf == LAST_BF) begin
                    r_bf  <= '0;
                    r_stg <= r_stg + 2'd1;
                end else begin
                    r_bf  <= r_bf + 2'd1;
                end
            end
        end
    end

    assign w_re     = r_re;
    assign w_im     = r_im;
    assign is_mj    = r_mj;
    assign tw_valid = r_tw_valid;
    assign stage    = r_stage_o;
    assign bfly     = r_bfly_o;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq: a cycle-level reference model feeds a scoreboard of expected beats.
module tb_twiddle_seq;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        mj;
        logic [1:0]  st;
        logic [1:0]  bf;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        inverse = 1'b0;
    logic        adv = 1'b0;
    logic [31:0] w_re;
    logic [31:0] w_im;
    logic        is_mj;
    logic        tw_valid;
    logic [1:0]  stage;
    logic [1:0]  bfly;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    beat_t sb[$];
    beat_t hold;
    int    m_state;
    int    m_beat;
    logic  m_inv;
    logic  m_busy;
    logic  exp_valid;
    logic  exp_done;
    int    n_done;

    twiddle_seq #(.W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inverse  (inverse),
        .adv      (adv),
        .w_re     (w_re),
        .w_im     (w_im),
        .is_mj    (is_mj),
        .tw_valid (tw_valid),
        .stage    (stage),
        .bfly     (bfly),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic beat_t ref_beat(input int b, input logic inv);
        beat_t r;
        int    k;
        r.st = 2'(b / 4);
        r.bf = 2'(b % 4);
        if (b < 4)      k = 0;
        else if (b < 8) k = 2 * ((b % 4) % 2);
        else            k = b % 4;
        r.mj = 1'b0;
        case (k)
            0: begin r.re = 32'h3F800000; r.im = 32'h00000000; end
            1: begin r.re = 32'h3F3504F3; r.im = inv ? 32'h3F3504F3 : 32'hBF3504F3; end
            2: begin r.re = 32'h00000000; r.im = inv ? 32'h3F800000 : 32'hBF800000; r.mj = !inv; end
            default: begin r.re = 32'hBF3504F3; r.im = inv ? 32'h3F3504F3 : 32'hBF3504F3; end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_beat  = 0;
        m_inv   = 1'b0;
        m_busy  = 1'b0;
        hold    = '0;
        sb.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".w_re"}, w_re, 32'h0);
        check({tag, ".w_im"}, w_im, 32'h0);
        check({tag, ".is_mj"}, is_mj, 0);
        check({tag, ".tw_valid"}, tw_valid, 0);
        check({tag, ".stage"}, stage, 0);
        check({tag, ".bfly"}, bfly, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cycle(input string tag, input logic s, input logic a);
        beat_t e;
        start     = s;
        adv       = a;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        case (m_state)
            0: if (s) begin
                m_state = 1; m_beat = 0; m_inv = inverse; m_busy = 1'b1;
                hold.st = 2'd0; hold.bf = 2'd0;
            end
            1: if (a) begin
                sb.push_back(ref_beat(m_beat, m_inv));
                exp_valid = 1'b1;
                m_beat++;
                if (m_beat == 12) m_state = 2;
            end
            default: begin
                m_state = 0; exp_done = 1'b1; m_busy = 1'b0;
            end
        endcase
        @(posedge clk);
        #1;
        start = 1'b0;
        adv   = 1'b0;
        if (done) n_done++;
        check({tag, ".tw_valid"}, tw_valid, exp_valid);
        check({tag, ".done"}, done, exp_done);
        check({tag, ".busy"}, busy, m_busy);
        if (exp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            hold = e;
        end
        check({tag, ".w_re"}, w_re, hold.re);
        check({tag, ".w_im"}, w_im, hold.im);
        check({tag, ".is_mj"}, is_mj, hold.mj);
        check({tag, ".stage"}, stage, hold.st);
        check({tag, ".bfly"}, bfly, hold.bf);
    endtask

    initial begin
        model_reset();
        n_done = 0;
        #2;
        check_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stray adv in IDLE must be ignored
        cycle("idle_adv", 1'b0, 1'b1);

        // Forward frame
        inverse = 1'b0;
        cycle("fwd_start", 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle("fwd", 1'b0, 1'b1);
        cycle("fwd_done", 1'b0, 1'b0);
        cycle("fwd_idle", 1'b0, 1'b0);
        check("fwd.done_count", n_done, 1);

        // Inverse frame
        inverse = 1'b1;
        cycle("inv_start", 1'b1, 1'b0);
        inverse = 1'b0;
        for (int i = 0; i < 12; i++) cycle("inv", 1'b0, 1'b1);
        cycle("inv_done", 1'b0, 1'b0);
        cycle("inv_idle", 1'b0, 1'b0);

        // Gapped adv, 1-in-3 duty
        cycle("gap_start", 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) cycle("gap", 1'b0, (i % 3) == 0);
        cycle("gap_done", 1'b0, 1'b0);
        cycle("gap_idle", 1'b0, 1'b0);

        // Start pulsed on beat 5 and on the 12th adv; both ignored
        n_done = 0;
        cycle("ign_start", 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle("ign", (i == 4) || (i == 11), 1'b1);
        cycle("ign_done", 1'b0, 1'b0);
        cycle("ign_idle1", 1'b0, 1'b0);
        cycle("ign_idle2", 1'b0, 1'b0);
        check("ign.done_count", n_done, 1);

        // Reset after beat 7 aborts the frame
        n_done = 0;
        cycle("rst_start", 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle("rst_pre", 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        check_zero("midrst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_rst_idle", 1'b0, 1'b0);

        // start+adv together in IDLE: only start acts
        cycle("sa_start", 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle("sa", 1'b0, 1'b1);
        cycle("sa_done", 1'b0, 1'b0);
        cycle("sa_idle", 1'b0, 1'b0);
        check("midrst.done_count", n_done, 1);
        check("sb.empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the IEEE-754 word width of the twiddle outputs; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a one-cycle pulse that begins an 8-point frame.
REQ-005 The block SHALL have port inverse, input, 1, which selects IFFT (conjugate twiddles) and is sampled only when start is accepted.
REQ-006 The block SHALL have port adv, input, 1, which requests the twiddle for the next butterfly.
REQ-007 The block SHALL have output ports w_re and w_im, each W bits, carrying the float32 twiddle for the butterfly multiplier.
REQ-008 The block SHALL have output port is_mj, 1 bit, which is high when the twiddle is exactly -j, so the multiplier takes its bypass path.
REQ-009 The block SHALL have output port tw_valid, 1 bit, which qualifies w_re, w_im, is_mj, stage and bfly.
REQ-010 The block SHALL have output port stage, 2 bits (0..2), and output port bfly, 2 bits (0..3), giving the current butterfly position.
REQ-011 The block SHALL have output ports busy, 1 bit, and done, 1 bit; done is a one-cycle pulse.

Function
REQ-012 The FSM SHALL use three states, IDLE, RUN and DONE:
- IDLE to RUN on start.
- RUN to DONE after the 12th accepted adv.
- DONE to IDLE unconditionally after one cycle.
REQ-013 A start SHALL be ignored unless the FSM is in IDLE, and adv SHALL be ignored unless the FSM is in RUN.
REQ-014 On accepting start, the block SHALL latch inverse, clear stage and bfly to 0, and set busy to 1.
REQ-015 Each adv in RUN SHALL produce a registered output with a latency of 1 cycle:
- tw_valid=1.
- The twiddle for the current (stage, bfly).
- bfly incremented afterwards, wrapping from 3 to 0 with stage incremented.
REQ-016 When adv is low, tw_valid SHALL be 0 in the next cycle, and the other outputs SHALL hold their values.
REQ-017 The twiddle exponent k SHALL be selected per stage:
- Stage 0: k=0.
- Stage 1: k = 2*(bfly mod 2).
- Stage 2: k = bfly.
- The twiddle is W8^k = exp(-j*2*pi*k/8).
REQ-018 The forward-mode constants SHALL be:
- k0 = (3F800000, 00000000).
- k1 = (3F3504F3, BF3504F3).
- k2 = (00000000, BF800000) with is_mj=1.
- k3 = (BF3504F3, BF3504F3).
- is_mj SHALL be 0 for every other k.
REQ-019 Inverse mode SHALL toggle bit 31 of w_im for k1 and k3.
REQ-020 Inverse mode SHALL output k2 as (00000000, 3F800000) with is_mj=0, since +j uses the generic path.
REQ-021 In inverse mode, k0 w_im SHALL stay 00000000 and never become negative zero.
REQ-022 done SHALL pulse in the cycle after the output of the 12th twiddle, and busy SHALL fall in that same cycle.
REQ-023 If start and adv are both high in IDLE, only start SHALL take effect, and no twiddle is emitted that cycle.
REQ-024 If start and the 12th adv coincide in RUN, start SHALL be ignored.

Reset
REQ-025 While rst_n is low, the block SHALL asynchronously force:
- FSM=IDLE, with latched inverse=0.
- tw_valid=0, w_re=0, w_im=0, is_mj=0, stage=0, bfly=0.
- busy=0, done=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse, and the first start after release SHALL begin a fresh frame at (0,0).

Structure
REQ-027 Package fft_pkg SHALL hold:
- The float32 constants FP_ONE, FP_ZERO, FP_RSQRT2 and FP_SIGN_MASK.
- The state enum.
- The constants N_PTS=8, N_STAGE=3 and N_BFLY=4.
REQ-028 The (k, inverse)-to-(w_re, w_im, is_mj) mapping SHALL be the combinational sub-module twiddle_rom.
REQ-029 The FSM, counters and output registers SHALL live in twiddle_seq.

Verification
REQ-030 Forward frame: start with inverse=0, then 12 consecutive adv.
- Expect 12 tw_valid beats, with k sequence 0,0,0,0, 0,2,0,2, 0,1,2,3.
- Expect is_mj=1 exactly on beats 6, 8 and 11 (1-based).
- Expect done on the cycle after beat 12.
REQ-031 Inverse frame: start with inverse=1.
- Beat 10 SHALL be (3F3504F3, 3F3504F3).
- Beat 11 SHALL be (00000000, 3F800000) with is_mj=0.
- No beat SHALL show is_mj=1.
REQ-032 Gapped adv: toggle adv with a 1-in-3 duty.
- Expect the same 12-value sequence as REQ-030.
- Outputs SHALL hold between beats, with tw_valid=0 there.
REQ-033 Ignored start: pulse start at beat 5 of a frame.
- The sequence and stage/bfly SHALL be unaffected.
- No extra done SHALL occur.
REQ-034 Mid-frame reset: assert rst_n=0 after beat 7.
- All outputs SHALL read 0 immediately.
- There SHALL be no done pulse.
- The next frame SHALL start at stage 0, bfly 0.
REQ-035 Simultaneous start+adv in IDLE: expect no tw_valid that cycle and busy=1 in the next cycle.
